// File: rtl/reg_stage_skid_if.sv
// Writeback bundle with valid/ready handshake between two pipeline stages.
// The master drives valid and payload; the slave returns ready.
interface reg_stage_skid_if #(
    parameter int DATA_W = 32,
    parameter int RN_W   = 5
) ();
    logic              valid;
    logic              ready;
    logic              wreg;
    logic              m2reg;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mo;
    logic [RN_W-1:0]   rn;

    modport master (output valid, wreg, m2reg, alu, mo, rn, input ready);
    modport slave  (input valid, wreg, m2reg, alu, mo, rn, output ready);
endinterface

// File: rtl/reg_stage_skid.sv
// Pipeline stage register for the writeback bundle with valid/ready handshake,
// optional 2-entry skid buffer (registered in_ready) and synchronous flush.
module reg_stage_skid #(
    parameter int DATA_W = 32,
    parameter int RN_W   = 5,
    parameter int SKID   = 1
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            flush,
    reg_stage_skid_if.slave  up,
    reg_stage_skid_if.master dn
);

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mo;
        logic [RN_W-1:0]   rn;
    } bundle_t;

    function automatic logic wreg_qual(input logic v, input logic w, input logic [RN_W-1:0] rn);
        return v && w && (rn != '0);
    endfunction

    bundle_t in_b;
    bundle_t main_p1, main_n;
    bundle_t skid_p0, skid_n;
    logic    main_vld_p1, main_vld_n;
    logic    skid_vld_p0, skid_vld_n;
    logic    in_ready;
    logic    accept;
    logic    drain;

    assign in_b = {up.wreg, up.m2reg, up.alu, up.mo, up.rn};

    generate
        if (SKID != 0) begin : g_ready_skid
            // Registered state only: no path from out_ready to in_ready.
            assign in_ready = !skid_vld_p0 && !clr;
        end else begin : g_ready_single
            assign in_ready = (!main_vld_p1 || dn.ready) && !clr;
        end
    endgenerate

    assign up.ready = in_ready;
    assign accept   = up.valid && in_ready;
    assign drain    = main_vld_p1 && dn.ready;

    always_comb begin
        main_vld_n = main_vld_p1;
        skid_vld_n = skid_vld_p0;
        main_n     = main_p1;
        skid_n     = skid_p0;
        if (SKID != 0) begin
            if (!main_vld_p1 || drain) begin
                if (skid_vld_p0) begin
                    main_vld_n = 1'b1;
                    main_n     = skid_p0;
                    skid_vld_n = accept;
                    if (accept) skid_n = in_b;
                end else begin
                    main_vld_n = accept;
                    if (accept) main_n = in_b;
                end
            end else if (accept) begin
                skid_vld_n = 1'b1;
                skid_n     = in_b;
            end
        end else begin
            if (accept) begin
                main_vld_n = 1'b1;
                main_n     = in_b;
            end else if (drain) begin
                main_vld_n = 1'b0;
            end
        end
        // Flush drops everything, including an input accepted this cycle.
        if (flush) begin
            main_vld_n = 1'b0;
            skid_vld_n = 1'b0;
            main_n     = main_p1;
            skid_n     = skid_p0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p0 <= 1'b0;
            main_p1     <= '0;
            skid_p0     <= '0;
        end else begin
            main_vld_p1 <= main_vld_n;
            skid_vld_p0 <= skid_vld_n;
            main_p1     <= main_n;
            skid_p0     <= skid_n;
        end
    end

    assign dn.valid = main_vld_p1;
    assign dn.wreg  = wreg_qual(main_vld_p1, main_p1.wreg, main_p1.rn);
    assign dn.m2reg = main_p1.m2reg;
    assign dn.alu   = main_p1.alu;
    assign dn.mo    = main_p1.mo;
    assign dn.rn    = main_p1.rn;

endmodule

// File: tb/tb_reg_stage_skid.sv
// Directed bench for reg_stage_skid: table of vectors on a SKID=1 instance,
// plus hand sequences for reset, and a SKID=0 toggling-ready run.
module tb_reg_stage_skid;

    logic clk;
    logic clr;
    logic flush1;
    logic flush0;
    int   tests;
    int   fails;

    reg_stage_skid_if #(.DATA_W(32), .RN_W(5)) u1_up ();
    reg_stage_skid_if #(.DATA_W(32), .RN_W(5)) u1_dn ();
    reg_stage_skid_if #(.DATA_W(32), .RN_W(5)) u0_up ();
    reg_stage_skid_if #(.DATA_W(32), .RN_W(5)) u0_dn ();

    reg_stage_skid #(.DATA_W(32), .RN_W(5), .SKID(1)) dut1 (
        .clk(clk), .clr(clr), .flush(flush1), .up(u1_up), .dn(u1_dn)
    );
    reg_stage_skid #(.DATA_W(32), .RN_W(5), .SKID(0)) dut0 (
        .clk(clk), .clr(clr), .flush(flush0), .up(u0_up), .dn(u0_dn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       iv;
        logic       wr;
        logic [4:0] rn;
        logic       ordy;
        logic       fl;
        logic       ev;
        logic       ewr;
        logic [4:0] ern;
        logic       eir;
    } vec_t;

    vec_t tv[$];

    function automatic logic [31:0] pay(input logic [4:0] r);
        return 32'hA5000000 | 32'(r);
    endfunction

    function automatic vec_t mk(input logic iv, input logic wr, input logic [4:0] rn,
                                input logic ordy, input logic fl, input logic ev,
                                input logic ewr, input logic [4:0] ern, input logic eir);
        vec_t v;
        v.iv = iv; v.wr = wr; v.rn = rn; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.ewr = ewr; v.ern = ern; v.eir = eir;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        u1_up.valid = v.iv;
        u1_up.wreg  = v.wr;
        u1_up.m2reg = v.rn[0];
        u1_up.rn    = v.rn;
        u1_up.alu   = pay(v.rn);
        u1_up.mo    = ~pay(v.rn);
        u1_dn.ready = v.ordy;
        flush1      = v.fl;
        @(posedge clk);
        #1;
        check({tag, "_out_valid"}, 32'(u1_dn.valid), 32'(v.ev));
        check({tag, "_out_wreg"},  32'(u1_dn.wreg),  32'(v.ewr));
        check({tag, "_in_ready"},  32'(u1_up.ready), 32'(v.eir));
        if (v.ev) begin
            check({tag, "_out_rn"},    32'(u1_dn.rn),    32'(v.ern));
            check({tag, "_out_alu"},   u1_dn.alu,        pay(v.ern));
            check({tag, "_out_mo"},    u1_dn.mo,         ~pay(v.ern));
            check({tag, "_out_m2reg"}, 32'(u1_dn.m2reg), 32'(v.ern[0]));
        end
    endtask

    initial begin
        logic pat [9];
        int   exp_q[$];
        int   nxt;
        int   drained;
        logic acc;
        logic drn;

        tests = 0;
        fails = 0;
        clr = 1'b1;
        flush1 = 1'b0;
        flush0 = 1'b0;
        u1_up.valid = 1'b0; u1_up.wreg = 1'b0; u1_up.m2reg = 1'b0;
        u1_up.alu = '0; u1_up.mo = '0; u1_up.rn = '0; u1_dn.ready = 1'b0;
        u0_up.valid = 1'b0; u0_up.wreg = 1'b0; u0_up.m2reg = 1'b0;
        u0_up.alu = '0; u0_up.mo = '0; u0_up.rn = '0; u0_dn.ready = 1'b0;

        // Streaming rn 1..8
        for (int k = 1; k <= 8; k++) tv.push_back(mk(1, 1, 5'(k), 1, 0, 1, 1, 5'(k), 1));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
        // Write qualification
        tv.push_back(mk(1, 1, 0, 1, 0, 1, 0, 0, 1));
        tv.push_back(mk(1, 1, 7, 1, 0, 1, 1, 7, 1));
        tv.push_back(mk(1, 0, 9, 1, 0, 1, 0, 9, 1));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
        // Backpressure A=3, B=4, C=5
        tv.push_back(mk(1, 1, 3, 0, 0, 1, 1, 3, 1));
        tv.push_back(mk(1, 1, 4, 0, 0, 1, 1, 3, 0));
        tv.push_back(mk(1, 1, 5, 0, 0, 1, 1, 3, 0));
        tv.push_back(mk(1, 1, 5, 1, 0, 1, 1, 4, 1));
        tv.push_back(mk(1, 1, 5, 1, 0, 1, 1, 5, 1));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
        // Flush with both entries held, then flush of an accepted input
        tv.push_back(mk(1, 1, 10, 0, 0, 1, 1, 10, 1));
        tv.push_back(mk(1, 1, 11, 0, 0, 1, 1, 10, 0));
        tv.push_back(mk(1, 1, 12, 0, 1, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, 1, 13, 0, 0, 1, 1, 13, 1));
        tv.push_back(mk(1, 1, 14, 0, 1, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(u1_dn.valid), 32'd0);
        check("rst_in_ready1", 32'(u1_up.ready), 32'd0);
        check("rst_in_ready0", 32'(u0_up.ready), 32'd0);
        check("rst_out_alu",   u1_dn.alu,        32'd0);
        clr = 1'b0;
        #1;
        check("rel_in_ready1", 32'(u1_up.ready), 32'd1);
        check("rel_in_ready0", 32'(u0_up.ready), 32'd1);

        for (int i = 0; i < tv.size(); i++) apply(tv[i], $sformatf("r%0d", i));

        // Mid-stream clr with both entries full
        apply(mk(1, 1, 15, 0, 0, 1, 1, 15, 1), "pre_rst_a");
        apply(mk(1, 1, 16, 0, 0, 1, 1, 15, 0), "pre_rst_b");
        u1_up.valid = 1'b0;
        clr = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(u1_dn.valid), 32'd0);
        check("mid_rst_in_ready",  32'(u1_up.ready), 32'd0);
        check("mid_rst_out_wreg",  32'(u1_dn.wreg),  32'd0);
        check("mid_rst_out_rn",    32'(u1_dn.rn),    32'd0);
        check("mid_rst_out_alu",   u1_dn.alu,        32'd0);
        check("mid_rst_out_mo",    u1_dn.mo,         32'd0);
        #1;
        clr = 1'b0;
        #1;
        check("mid_rel_in_ready",  32'(u1_up.ready), 32'd1);
        check("mid_rel_out_valid", 32'(u1_dn.valid), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rel_stays_empty", 32'(u1_dn.valid), 32'd0);

        // SKID=0: in_valid held while out_ready toggles
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        nxt = 20;
        drained = 0;
        for (int c = 0; c < 12; c++) begin
            u0_up.valid = (c < 7);
            u0_up.wreg  = 1'b1;
            u0_up.m2reg = 1'b0;
            u0_up.rn    = 5'(nxt);
            u0_up.alu   = pay(5'(nxt));
            u0_up.mo    = ~pay(5'(nxt));
            u0_dn.ready = (c < 9) ? pat[c] : 1'b1;
            #1;
            if (u0_dn.valid)
                check($sformatf("s0_in_ready_full_c%0d", c), 32'(u0_up.ready), 32'(u0_dn.ready));
            else
                check($sformatf("s0_in_ready_empty_c%0d", c), 32'(u0_up.ready), 32'd1);
            acc = u0_up.valid && u0_up.ready;
            drn = u0_dn.valid && u0_dn.ready;
            if (drn) begin
                drained++;
                if (exp_q.size() == 0)
                    check($sformatf("s0_dup_c%0d", c), 32'(u0_dn.rn), 32'hFFFFFFFF);
                else
                    check($sformatf("s0_order_c%0d", c), 32'(u0_dn.rn), 32'(exp_q.pop_front()));
            end
            if (acc) begin
                exp_q.push_back(nxt);
                nxt++;
            end
            @(posedge clk);
            #1;
        end
        check("s0_accepted", 32'(nxt), 32'd24);
        check("s0_drained",  32'(drained), 32'd4);
        check("s0_left",     32'(exp_q.size()), 32'd0);
        check("s0_final_valid", 32'(u0_dn.valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
